// File: rtl/ccsds_turbo_pkg.sv
// Shared types, default CCSDS polynomials and the puncture-mask lookup
// used by both constituent encoders of the turbo encoder.
package ccsds_turbo_pkg;

    typedef enum logic [1:0] {
        RATE_1_2 = 2'd0,
        RATE_1_3 = 2'd1,
        RATE_1_4 = 2'd2,
        RATE_1_6 = 2'd3
    } rate_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } enc_state_e;

    // Bit MEM is the D^0 coefficient, bit MEM-j the D^j coefficient.
    localparam int         CCSDS_MEM = 4;
    localparam logic [4:0] CCSDS_G0  = 5'b10011;
    localparam logic [4:0] CCSDS_G1  = 5'b11011;
    localparam logic [4:0] CCSDS_G2  = 5'b10101;
    localparam logic [4:0] CCSDS_G3  = 5'b11111;

    // Mask bits are ordered {s, 1x, 2x, 3x} like the symbol itself.
    function automatic logic [3:0] punct_mask(input int enc_id, input rate_e rate,
                                              input logic odd);
        logic [3:0] m;
        m = 4'b0000;
        if (enc_id == 0) begin
            case (rate)
                RATE_1_2: m = odd ? 4'b1000 : 4'b1100;
                RATE_1_3: m = 4'b1100;
                RATE_1_4: m = 4'b1011;
                default:  m = 4'b1111;
            endcase
        end else begin
            case (rate)
                RATE_1_2: m = odd ? 4'b0100 : 4'b0000;
                RATE_1_3: m = 4'b0100;
                RATE_1_4: m = 4'b0100;
                default:  m = 4'b0101;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ccsds_rsc_trellis.sv
// Combinational RSC trellis step: feedback, three parities and next state.
// state[j-1] holds s[j]; s[1] is the newest bit.
module ccsds_rsc_trellis
    import ccsds_turbo_pkg::*;
#(
    parameter int           MEM = CCSDS_MEM,
    parameter logic [MEM:0] G0  = CCSDS_G0,
    parameter logic [MEM:0] G1  = CCSDS_G1,
    parameter logic [MEM:0] G2  = CCSDS_G2,
    parameter logic [MEM:0] G3  = CCSDS_G3
) (
    input  logic [MEM-1:0] state,
    input  logic           u,
    input  logic           term,
    output logic [MEM-1:0] next_state,
    output logic           sys,
    output logic [2:0]     parity
);

    logic       fb;
    logic       a;
    logic [2:0] taps;

    always_comb begin
        fb   = 1'b0;
        taps = 3'b000;
        for (int j = 1; j <= MEM; j++) begin
            fb      = fb      ^ (G0[MEM-j] & state[j-1]);
            taps[2] = taps[2] ^ (G1[MEM-j] & state[j-1]);
            taps[1] = taps[1] ^ (G2[MEM-j] & state[j-1]);
            taps[0] = taps[0] ^ (G3[MEM-j] & state[j-1]);
        end
        // Termination feeds the feedback back in so the register input is zero.
        sys        = term ? fb : u;
        a          = sys ^ fb;
        parity     = taps ^ ({G1[MEM], G2[MEM], G3[MEM]} & {3{a}});
        next_state = {state[MEM-2:0], a};
    end

endmodule

// File: rtl/ccsds_turbo_rsc_enc_param.sv
// Parametrised CCSDS turbo constituent encoder with block counter, self-generated
// trellis termination, puncture mask and a single registered output stage.
module ccsds_turbo_rsc_enc_param
    import ccsds_turbo_pkg::*;
#(
    parameter int           MEM    = CCSDS_MEM,
    parameter logic [MEM:0] G0     = CCSDS_G0,
    parameter logic [MEM:0] G1     = CCSDS_G1,
    parameter logic [MEM:0] G2     = CCSDS_G2,
    parameter logic [MEM:0] G3     = CCSDS_G3,
    parameter int           K_MAX  = 16384,
    parameter int           ENC_ID = 0,
    parameter int           LW     = $clog2(K_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_data,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [LW-1:0] i_blk_len,
    input  logic [1:0]    i_rate,
    output logic [3:0]    o_data,
    output logic [3:0]    o_mask,
    output logic          o_tail,
    output logic          o_last,
    output logic          o_valid,
    input  logic          i_ready
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and a held symbol stays stable.
    enc_state_e     fsm;
    logic [MEM-1:0] trel_state;
    logic [MEM-1:0] trel_next;
    logic [LW-1:0]  blk_len;
    logic [LW-1:0]  cnt;
    logic [LW-1:0]  k_in;
    rate_e          rate;
    rate_e          rate_now;
    logic           n_odd;
    logic           n_now;
    logic           advance;
    logic           in_hs;
    logic           term;
    logic           tail_go;
    logic           load;
    logic           sys;
    logic [2:0]     parity;

    assign advance  = !o_valid || i_ready;
    assign o_ready  = (fsm != ST_TAIL) && advance;
    assign in_hs    = o_ready && i_valid;
    assign term     = (fsm == ST_TAIL);
    assign tail_go  = term && advance;
    assign load     = in_hs || tail_go;
    assign k_in     = (i_blk_len == '0) ? LW'(1) : i_blk_len;
    // The first symbol of a block uses the parameters being latched this cycle.
    assign rate_now = (fsm == ST_IDLE) ? rate_e'(i_rate) : rate;
    assign n_now    = (fsm == ST_IDLE) ? 1'b0 : n_odd;

    ccsds_rsc_trellis #(
        .MEM (MEM),
        .G0  (G0),
        .G1  (G1),
        .G2  (G2),
        .G3  (G3)
    ) u_trellis (
        .state      (trel_state),
        .u          (i_data),
        .term       (term),
        .next_state (trel_next),
        .sys        (sys),
        .parity     (parity)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= ST_IDLE;
            trel_state <= '0;
            blk_len    <= '0;
            cnt        <= '0;
            rate       <= RATE_1_2;
            n_odd      <= 1'b0;
            o_data     <= 4'b0000;
            o_mask     <= 4'b0000;
            o_tail     <= 1'b0;
            o_last     <= 1'b0;
            o_valid    <= 1'b0;
        end else begin
            if (load) begin
                trel_state <= trel_next;
                o_data     <= {sys, parity};
                o_mask     <= punct_mask(ENC_ID, rate_now, n_now);
                o_tail     <= term;
                o_last     <= term && (cnt == LW'(MEM - 1));
                o_valid    <= 1'b1;
                n_odd      <= ~n_now;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end

            case (fsm)
                ST_IDLE: begin
                    if (in_hs) begin
                        blk_len <= k_in;
                        rate    <= rate_now;
                        if (k_in == LW'(1)) begin
                            fsm <= ST_TAIL;
                            cnt <= '0;
                        end else begin
                            fsm <= ST_DATA;
                            cnt <= LW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (in_hs) begin
                        if (cnt + LW'(1) == blk_len) begin
                            fsm <= ST_TAIL;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + LW'(1);
                        end
                    end
                end
                ST_TAIL: begin
                    // In TAIL the counter indexes the termination symbol.
                    if (tail_go) begin
                        if (cnt == LW'(MEM - 1)) begin
                            fsm <= ST_IDLE;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + LW'(1);
                        end
                    end
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccsds_turbo_rsc_enc_param.sv
// Bench for ccsds_turbo_rsc_enc_param: encoders a and b share stimulus; hand-computed
// directed blocks, stalls, reset mid-tail, then random blocks against a small model.
module tb_ccsds_turbo_rsc_enc_param;

    localparam int LW = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_data = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b1;
    logic [LW-1:0] i_blk_len = '0;
    logic [1:0]    i_rate = 2'd0;

    logic       a_ready, a_tail, a_last, a_valid;
    logic [3:0] a_data, a_mask;
    logic       b_ready, b_tail, b_last, b_valid;
    logic [3:0] b_data, b_mask;

    int total = 0;
    int bad = 0;
    int out_cnt = 0;
    int last_cnt = 0;
    int cyc = 0;
    int stall_until = -1;
    bit mon_en = 1'b0;
    bit rnd_ready = 1'b0;

    logic [9:0] exp_q[$];
    logic [3:0] exp_b_q[$];
    logic [3:0] ms = 4'b0000;
    int         mn = 0;

    ccsds_turbo_rsc_enc_param #(.ENC_ID(0)) dut_a (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(a_ready),
        .i_blk_len(i_blk_len), .i_rate(i_rate), .o_data(a_data), .o_mask(a_mask),
        .o_tail(a_tail), .o_last(a_last), .o_valid(a_valid), .i_ready(i_ready)
    );

    ccsds_turbo_rsc_enc_param #(.ENC_ID(1)) dut_b (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(b_ready),
        .i_blk_len(i_blk_len), .i_rate(i_rate), .o_data(b_data), .o_mask(b_mask),
        .o_tail(b_tail), .o_last(b_last), .o_valid(b_valid), .i_ready(i_ready)
    );

    // ---------------- clock / reset / downstream ready ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (rnd_ready) i_ready = ($urandom_range(0, 3) != 0);
        else           i_ready = !(cyc <= stall_until);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] mask_a(input int rate, input int n);
        case (rate)
            0:       return (n % 2 == 1) ? 4'b1000 : 4'b1100;
            1:       return 4'b1100;
            2:       return 4'b1011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [3:0] mask_b(input int rate, input int n);
        case (rate)
            0:       return (n % 2 == 1) ? 4'b0100 : 4'b0000;
            1:       return 4'b0100;
            2:       return 4'b0100;
            default: return 4'b0101;
        endcase
    endfunction

    // Hand-derived equations for the default polynomials (s1 newest):
    // a = u^s3^s4, 1x = a^s1^s3^s4, 2x = a^s2^s4, 3x = a^s1^s2^s3^s4.
    task automatic model_sym(input logic u_in, input logic tl, input logic lst, input int rate);
        logic s1, s2, s3, s4, u, a, p1, p2, p3;
        {s4, s3, s2, s1} = ms;
        u  = tl ? (s3 ^ s4) : u_in;
        a  = u ^ s3 ^ s4;
        p1 = a ^ s1 ^ s3 ^ s4;
        p2 = a ^ s2 ^ s4;
        p3 = a ^ s1 ^ s2 ^ s3 ^ s4;
        exp_q.push_back({u, p1, p2, p3, mask_a(rate, mn), tl, lst});
        exp_b_q.push_back(mask_b(rate, mn));
        ms = {s3, s2, s1, a};
        mn = mn + 1;
    endtask

    // Directed expectation: symbol i is nibble i of dvec counted from the top.
    task automatic exp_dir(input logic [31:0] dvec, input int nsym, input int rate);
        logic       tl;
        logic [3:0] d;
        for (int i = 0; i < nsym; i++) begin
            tl = (i >= nsym - 4);
            d  = dvec[4*(nsym-1-i) +: 4];
            exp_q.push_back({d, mask_a(rate, i), tl, (i == nsym - 1)});
            exp_b_q.push_back(mask_b(rate, i));
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [9:0] cur;
    logic [9:0] held;
    logic [9:0] e_sym;
    logic [3:0] e_mb;
    bit         stalled_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            cur = {a_data, a_mask, a_tail, a_last};
            if (stalled_prev && a_valid) check("hold_stable", 32'(cur), 32'(held));
            if (a_valid && !i_ready) begin
                check("ready_a_stall", 32'(a_ready), 32'd0);
                check("ready_b_stall", 32'(b_ready), 32'd0);
                held = cur;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (a_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_symbol", 32'd1, 32'd0);
                end else begin
                    e_sym = exp_q.pop_front();
                    e_mb  = exp_b_q.pop_front();
                    check("data_a", 32'(a_data), 32'(e_sym[9:6]));
                    check("mask_a", 32'(a_mask), 32'(e_sym[5:2]));
                    check("tail_a", 32'(a_tail), 32'(e_sym[1]));
                    check("last_a", 32'(a_last), 32'(e_sym[0]));
                    check("valid_b", 32'(b_valid), 32'd1);
                    check("data_b", 32'(b_data), 32'(e_sym[9:6]));
                    check("mask_b", 32'(b_mask), 32'(e_mb));
                    check("tail_b", 32'(b_tail), 32'(e_sym[1]));
                    check("last_b", 32'(b_last), 32'(e_sym[0]));
                end
                out_cnt = out_cnt + 1;
                if (a_last) last_cnt = last_cnt + 1;
            end
        end else begin
            stalled_prev = 1'b0;
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic send_bit(input logic u, input logic [LW-1:0] len, input logic [1:0] rate);
        bit hs;
        int n;
        i_data = u;
        i_blk_len = len;
        i_rate = rate;
        i_valid = 1'b1;
        hs = 1'b0;
        n = 0;
        while (!hs && n < 1000) begin
            @(negedge clk);
            hs = a_ready;
            @(posedge clk);
            #1;
            n = n + 1;
        end
        if (!hs) check("send_timeout", 32'd0, 32'd1);
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n = n + 1;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic stall_at(input int target);
        int n;
        n = 0;
        while (out_cnt < target && n < 1000) begin
            @(negedge clk);
            n = n + 1;
        end
        if (out_cnt < target) check("stall_timeout", 32'(out_cnt), 32'(target));
        stall_until = cyc + 5;
    endtask

    // ---------------- directed + random sequence ----------------
    int   base;
    int   base_last;
    int   k;
    int   r;
    logic u;
    int   n_wait;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_data", 32'(a_data), 32'd0);
        check("rst_mask", 32'(a_mask), 32'd0);
        check("rst_tail", 32'(a_tail), 32'd0);
        check("rst_last", 32'(a_last), 32'd0);
        check("rst_ready", 32'(a_ready), 32'd1);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // K=1, u=1, rate 1/6: 1111 then tails 0101 0011 1101 1111
        exp_dir(32'h000F53DF, 5, 3);
        send_bit(1'b1, LW'(1), 2'd3);
        wait_drain();

        // K=0 is treated as K=1
        exp_dir(32'h000F53DF, 5, 3);
        send_bit(1'b1, LW'(0), 2'd3);
        wait_drain();

        // K=2, bits 1,0, rate 1/6: 1111 0101 | 0011 1101 1111 0000
        exp_dir(32'h00F53DF0, 6, 3);
        send_bit(1'b1, LW'(2), 2'd3);
        send_bit(1'b0, LW'(2), 2'd3);
        wait_drain();

        // K=4, bits 1,0,0,0, rate 1/2: 1111 0101 0011 0010 | 1010 0011 1101 1111
        exp_dir(32'hF532A3DF, 8, 0);
        send_bit(1'b1, LW'(4), 2'd0);
        send_bit(1'b0, LW'(4), 2'd0);
        send_bit(1'b0, LW'(4), 2'd0);
        send_bit(1'b0, LW'(4), 2'd0);
        wait_drain();

        // Same block at rate 1/4 with stalls in DATA and in TAIL
        base = out_cnt;
        exp_dir(32'hF532A3DF, 8, 2);
        fork
            begin
                send_bit(1'b1, LW'(4), 2'd2);
                send_bit(1'b0, LW'(4), 2'd2);
                send_bit(1'b0, LW'(4), 2'd2);
                send_bit(1'b0, LW'(4), 2'd2);
            end
            begin
                stall_at(base + 2);
                stall_at(base + 5);
            end
        join
        wait_drain();

        // Reset while tail symbol 2 is on the output
        base = out_cnt;
        exp_dir(32'h000F53DF, 5, 3);
        send_bit(1'b1, LW'(1), 2'd3);
        n_wait = 0;
        while (out_cnt < base + 2 && n_wait < 1000) begin
            @(posedge clk);
            #1;
            n_wait = n_wait + 1;
        end
        check("reach_tail2", 32'(out_cnt - base), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_b_q.delete();
        @(negedge clk);
        check("mid_rst_valid", 32'(a_valid), 32'd0);
        check("mid_rst_data", 32'(a_data), 32'd0);
        check("mid_rst_mask", 32'(a_mask), 32'd0);
        check("mid_rst_tail", 32'(a_tail), 32'd0);
        check("mid_rst_last", 32'(a_last), 32'd0);
        check("mid_rst_ready", 32'(a_ready), 32'd1);
        @(posedge clk);
        #1;
        exp_dir(32'h000F53DF, 5, 3);
        send_bit(1'b1, LW'(1), 2'd3);
        wait_drain();

        // Random blocks with random backpressure and junk parameters after the first bit
        rnd_ready = 1'b1;
        base_last = last_cnt;
        ms = 4'b0000;
        for (int b = 0; b < 100; b++) begin
            k = $urandom_range(1, 64);
            r = $urandom_range(0, 3);
            mn = 0;
            for (int i = 0; i < k; i++) begin
                u = 1'($urandom_range(0, 1));
                model_sym(u, 1'b0, 1'b0, r);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                if (i == 0) send_bit(u, LW'(k), 2'(r));
                else        send_bit(u, LW'($urandom_range(0, 100)), 2'($urandom_range(0, 3)));
            end
            for (int t = 0; t < 4; t++) model_sym(1'b0, 1'b1, (t == 3), r);
        end
        wait_drain();
        rnd_ready = 1'b0;
        check("last_per_block", 32'(last_cnt - base_last), 32'd100);
        check("b_queue_empty", 32'(exp_b_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ccsds_turbo_rsc_enc_param.md
# ccsds_turbo_rsc_enc_param

Parametrised CCSDS turbo constituent encoder that succeeds the fixed 16-state RSC encoder. It adds generic memory and generator polynomials, a per-block length counter with self-generated trellis termination, valid/ready handshakes on both sides, and a per-symbol puncture mask for code rates 1/2, 1/3, 1/4 and 1/6. Two instances, with ENC_ID=0 and ENC_ID=1, sit after the interleaver in the turbo encoder top and feed the rate multiplexer.

## Interface
- MEM, 4: constraint memory (number of state registers).
- G0, 5'b10011: feedback polynomial, MEM+1 bits. Bit MEM is the D^0 coefficient; bit MEM-j is the D^j coefficient.
- G1, 5'b11011 / G2, 5'b10101 / G3, 5'b11111: forward polynomials for parity outputs 1x/2x/3x. Same bit ordering as G0.
- K_MAX, 16384: maximum information block length.
- ENC_ID, 0: 0 = encoder a, 1 = encoder b. Selects the puncture pattern.
- LW, $clog2(K_MAX+1): length width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_data  in  1  information bit.
- i_valid  in  1  input bit valid.
- o_ready  out  1  encoder accepts input.
- i_blk_len  in  LW  block length K, latched with the first bit of a block. Legal range 1..K_MAX.
- i_rate  in  2  code rate, latched with the first bit: 0 = 1/2, 1 = 1/3, 2 = 1/4, 3 = 1/6.
- o_data  out  4  symbol {s, 1x, 2x, 3x}, MSB first.
- o_mask  out  4  per-bit transmit mask, aligned with o_data.
- o_tail  out  1  symbol is a termination symbol.
- o_last  out  1  final symbol of the block.
- o_valid  out  1  output symbol valid.
- i_ready  in  1  downstream accepts the symbol.

## Operation
- **State register.** The state s[1..MEM] is all zeros at block start; s[1] is the newest bit.
  - Feedback: a = u ^ XOR over j=1..MEM of (G0[MEM-j] & s[j]).
  - Parity for each i: p_i = XOR over j=0..MEM of (Gi[MEM-j] & w[j]), where w[0] = a and w[j] = s[j].
  - Update: s <= {a, s[1..MEM-1]}.
- **FSM states.**
  - IDLE: o_ready = 1. On the first input handshake, latch i_blk_len and i_rate, clear the counter, encode the bit, and go to DATA. If i_blk_len = 1, go directly to TAIL.
  - DATA: encode u = i_data on each input handshake. Go to TAIL after the K-th accepted bit.
  - TAIL: o_ready = 0. The block self-generates MEM symbols with u = XOR of the feedback taps, so a = 0. The systematic output s equals u. After MEM tail symbols, return to IDLE with state = 0.
- **Symbol index.** The index n counts all symbols of the block, tail included, starting at 0.
- **Mask, ENC_ID=0:**
  - rate 1/2: 1100 for even n, 1000 for odd n.
  - rate 1/3: 1100.
  - rate 1/4: 1011.
  - rate 1/6: 1111.
- **Mask, ENC_ID=1:**
  - rate 1/2: 0000 for even n, 0100 for odd n.
  - rate 1/3: 0100.
  - rate 1/4: 0100.
  - rate 1/6: 0101.
- **o_data.** Unmasked bits still carry the computed values; o_mask only flags them.
- **o_tail / o_last.** o_tail = 1 on all MEM tail symbols. o_last = 1 only on the MEM-th tail symbol.
- **Illegal length.** i_blk_len = 0 is treated as 1.

## Timing
- **Output register.** There is a single output register.
  - Input handshake: o_ready & i_valid in IDLE or DATA.
  - Output handshake: o_valid & i_ready.
  - o_ready = (state != TAIL) & (!o_valid | i_ready).
- **Latency.** The symbol for an accepted bit appears on o_data one cycle after acceptance. Sustained throughput is 1 symbol per cycle when i_ready = 1.
- **Backpressure.** While o_valid = 1 and i_ready = 0, all outputs hold stable and neither state nor counter advances.
- **Tail timing.** Tail symbols issue on consecutive cycles when i_ready = 1. With no backpressure, the first tail symbol follows the K-th data symbol with no bubble.
- **Back-to-back blocks.** In the IDLE cycle that follows the last tail symbol's register load, a new block may be accepted. The first symbol of the next block may follow o_last with a gap of at most one cycle.
- **Reset.** rst = 1 at any time, including mid-block or mid-tail, forces:
  - state register = 0, counter = 0, FSM = IDLE, n = 0;
  - o_valid = 0, o_data = 0, o_mask = 0, o_tail = 0, o_last = 0;
  - o_ready = 1 from the first cycle after reset deasserts.
- **Latched parameters.** i_blk_len and i_rate are ignored outside the IDLE acceptance cycle.

## Structure
- Shared package ccsds_turbo_pkg holds:
  - the rate enum (RATE_1_2 = 0, RATE_1_3 = 1, RATE_1_4 = 2, RATE_1_6 = 3);
  - the FSM state typedef;
  - the default CCSDS polynomials;
  - the function that maps (ENC_ID, rate, n[0]) to a puncture mask.
- One sub-module, ccsds_rsc_trellis, is natural. It is purely combinational: it takes (state, u, term) and returns (next_state, a, parity[2:0]), and is parametrised on MEM/G0..G3. The top keeps the FSM, counter and handshake.

## Test plan
- **Single bit, K=1, rate 1/6, ENC_ID=0, defaults.**
  - Stimulus: u = 1.
  - Required: first symbol o_data = 1111, mask 1111; then 4 tail symbols with o_tail = 1 and o_last on the 4th; the final state returns to 0.
- **Two bits, K=2, rate 1/6.**
  - Stimulus: bits 1, 0.
  - Required: symbols 1111 then 0101; 6 symbols total.
- **Rate 1/2 masks, K=4.**
  - ENC_ID=0: masks 1100, 1000, 1100, 1000, ... over 8 symbols.
  - ENC_ID=1: masks 0000, 0100, ... over 8 symbols.
- **Backpressure.**
  - Stimulus: i_ready held low for 5 cycles in mid-DATA and again in mid-TAIL.
  - Required: outputs stable throughout; o_ready = 0 while stalled; the symbol sequence matches the no-stall run bit-exactly.
- **Reset mid-tail.**
  - Stimulus: rst pulse during tail symbol 2.
  - Required: next cycle o_valid = 0 and all outputs 0; the following block with K=1, u=1 gives 1111 again.
- **Random 100 blocks.**
  - Stimulus: K in 1..64 with a random rate.
  - Required: output matches the reference model; every tail ends with a zero state; o_last once per block.
